green_issue: RTL and testbench
==============================

Name: green_issue

Overview:
Single-issue fetch/decode/issue sequencer directly upstream of the green datapath. Fetches 16-bit instruction words from a synchronous instruction memory and reads operands from a local 16x16 register file. Presents opCode/A_in/B_in to green under a valid/ready handshake, then writes green's A_out result back to the register file. Strictly serial: one instruction in flight, so there are no hazards.

Parameters:
PC_W, 8, program counter and instruction address width
RST_PC, 0, PC value loaded at reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  stage enable; low = freeze all state
start  in  1  begin execution at start_pc (sampled in IDLE/HALT only)
start_pc  in  PC_W  first instruction address
imem_addr  out  PC_W  instruction memory address
imem_rd  out  1  instruction read strobe; data valid the following cycle
imem_data  in  16  instruction word
opCode  out  16  full instruction word to green
A_in  out  16  operand A to green
B_in  out  16  operand B to green
issue_valid  out  1  opCode/A_in/B_in valid
issue_ready  in  1  green accepts issue
wb_data  in  16  result from green (A_out)
wb_valid  in  1  wb_data valid
pc  out  PC_W  current PC
busy  out  1  state not IDLE/HALT
halted  out  1  HALT state

Behaviour:
- Instruction fields: op=[15:12], rd=[11:8], ra=[7:4], rb=[3:0]. r0 always reads 0; writes to r0 are discarded.
- Reset (async, rst_n=0): state IDLE; pc=RST_PC; all registers, opCode, A_in, B_in=0; issue_valid, imem_rd, busy, halted=0; imem_addr=0.
- en=0: no state, pc, or register changes; outputs hold. wb_valid and issue_ready are ignored while en=0.
- IDLE: on start → pc<=start_pc, go to FETCH.
- FETCH (1 cycle): imem_rd=1, imem_addr=pc → DECODE.
- DECODE: ir<=imem_data, then dispatch on op:
  - 4'hF HALT → HALT; pc is not advanced.
  - 4'hE LDI → reg[rd]<={8'h00,ra,rb}; pc<=pc+1; go to FETCH. Not issued to green.
  - All other ops → opCode<=word, A_in<=reg[ra], B_in<=reg[rb], issue_valid<=1; go to ISSUE.
- ISSUE: hold issue_valid and outputs stable until issue_ready=1. The transfer occurs in that cycle. Next edge: issue_valid<=0, go to WB.
- WB: wait for wb_valid; reg[rd]<=wb_data; pc<=pc+1; go to FETCH. wb_valid in any other state is ignored.
- HALT: halted=1. start → pc<=start_pc, go to FETCH.
- Latency: LDI takes 3 cycles/instruction (FETCH, DECODE, write). A non-LDI instruction with ready and wb_valid both immediately high takes 4 cycles (FETCH, DECODE, ISSUE, WB).
- pc wraps modulo 2^PC_W (8'hFF+1=8'h00).
- start asserted in any state other than IDLE/HALT is ignored.
- Reset mid-ISSUE/WB: the pending instruction is abandoned and issue_valid drops immediately (asynchronously).
- An LDI followed by an instruction reading the same register sees the new value, because the write completes before the next DECODE.

Optional Feature:
GREEN_ISSUE_BRANCH_EN
- Defined: op 4'hD = BNZ. In DECODE, if reg[rd]!=0 then pc<=pc+signext({ra,rb}) (modulo 2^PC_W), else pc<=pc+1. Go to FETCH; not issued. BNZ with rd=0 never branches.
- Undefined: op 4'hD is issued to green like any other op.

Test Plan:
- Reset then start, start_pc=8'h10: imem_rd=1 with imem_addr=8'h10 one cycle after start; all outputs 0 before start.
- Program LDI r1,8'h12; LDI r2,8'h34; op 4'h1 r3,r1,r2: issue_valid=1 with opCode=16'h1312, A_in=16'h0012, B_in=16'h0034. wb_data=16'h0046 → later issue reading r3 shows 16'h0046.
- Hold issue_ready=0 for 5 cycles: outputs stable, issue_valid held high, no pc change. Ready=1 → single transfer, issue_valid low next cycle.
- Write to r0 via wb (rd=0, wb_data=16'hFFFF): subsequent read of r0 gives 0. HALT at 8'hFF → halted=1, pc=8'hFF. Restart with start_pc=8'hFF, LDI there → next fetch at 8'h00.
- en=0 during WB with wb_valid pulsed: register not written, state held. en=1 with wb_valid → write occurs. rst_n low mid-ISSUE: issue_valid drops immediately, state IDLE.
- With GREEN_ISSUE_BRANCH_EN: r1=1, BNZ r1,-2 at 8'h05 → next fetch 8'h03. r1=0 → next fetch 8'h06. Without the macro: the same word is issued with opCode=16'hD1FE.

Source files
------------

// File: rtl/green_issue_if.sv
// Issue/writeback channel between the green_issue sequencer (master) and the green datapath (slave).
interface green_issue_if;
    logic [15:0] opCode;
    logic [15:0] A_in;
    logic [15:0] B_in;
    logic        issue_valid;
    logic        issue_ready;
    logic [15:0] wb_data;
    logic        wb_valid;

    modport master (
        output opCode, A_in, B_in, issue_valid,
        input  issue_ready, wb_data, wb_valid
    );

    modport slave (
        input  opCode, A_in, B_in, issue_valid,
        output issue_ready, wb_data, wb_valid
    );
endinterface

// File: rtl/green_issue.sv
// Serial fetch/decode/issue sequencer in front of green; one instruction in flight at a time.
// Build option GREEN_ISSUE_BRANCH_EN makes op 4'hD a locally executed BNZ instead of a green op.
module green_issue #(
    parameter int              PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            start,
    input  logic [PC_W-1:0] start_pc,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd,
    input  logic [15:0]     imem_data,
    green_issue_if.master   gif,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_LDW    = 3'd3,
        S_ISSUE  = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0]      OP_HALT = 4'hF;
    localparam logic [3:0]      OP_LDI  = 4'hE;
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1'b1);
`ifdef GREEN_ISSUE_BRANCH_EN
    localparam logic [3:0]      OP_BNZ  = 4'hD;
`endif

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] imem_addr_q;
    logic            imem_rd_q;
    logic [11:0]     ir_q;
    logic [15:0]     regs_q [16];
    logic [15:0]     opcode_q;
    logic [15:0]     a_q;
    logic [15:0]     b_q;
    logic            issue_valid_q;
    logic            busy_q;
    logic            halted_q;
    logic [PC_W-1:0] pc_inc_d;

    // Sequential successor of the current instruction address, wrapping at 2^PC_W.
    always_comb begin
        pc_inc_d = pc_q + PC_ONE;
    end

`ifdef GREEN_ISSUE_BRANCH_EN
    logic [PC_W-1:0] br_tgt_d;

    // Branch target: {ra,rb} of the word in DECODE is a signed 8-bit displacement.
    always_comb begin
        br_tgt_d = pc_q + PC_W'($signed(imem_data[7:0]));
    end
`endif

    // Sequencer FSM together with the register file and every registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RST_PC;
            imem_addr_q   <= {PC_W{1'b0}};
            imem_rd_q     <= 1'b0;
            ir_q          <= 12'h000;
            opcode_q      <= 16'h0000;
            a_q           <= 16'h0000;
            b_q           <= 16'h0000;
            issue_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else if (en) begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc_q        <= start_pc;
                        imem_addr_q <= start_pc;
                        imem_rd_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        halted_q    <= 1'b0;
                        state_q     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    imem_rd_q <= 1'b0;
                    state_q   <= S_DECODE;
                end
                S_DECODE: begin
                    ir_q <= imem_data[11:0];
                    if (imem_data[15:12] == OP_HALT) begin
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else if (imem_data[15:12] == OP_LDI) begin
                        state_q <= S_LDW;
                    end
`ifdef GREEN_ISSUE_BRANCH_EN
                    else if (imem_data[15:12] == OP_BNZ) begin
                        // r0 is held at zero, so BNZ on r0 always falls through.
                        if (regs_q[imem_data[11:8]] != 16'h0000) begin
                            pc_q        <= br_tgt_d;
                            imem_addr_q <= br_tgt_d;
                        end else begin
                            pc_q        <= pc_inc_d;
                            imem_addr_q <= pc_inc_d;
                        end
                        imem_rd_q <= 1'b1;
                        state_q   <= S_FETCH;
                    end
`endif
                    else begin
                        opcode_q      <= imem_data;
                        a_q           <= regs_q[imem_data[7:4]];
                        b_q           <= regs_q[imem_data[3:0]];
                        issue_valid_q <= 1'b1;
                        state_q       <= S_ISSUE;
                    end
                end
                S_LDW: begin
                    if (ir_q[11:8] != 4'h0) begin
                        regs_q[ir_q[11:8]] <= {8'h00, ir_q[7:0]};
                    end
                    pc_q        <= pc_inc_d;
                    imem_addr_q <= pc_inc_d;
                    imem_rd_q   <= 1'b1;
                    state_q     <= S_FETCH;
                end
                S_ISSUE: begin
                    if (gif.issue_ready) begin
                        issue_valid_q <= 1'b0;
                        state_q       <= S_WB;
                    end
                end
                S_WB: begin
                    if (gif.wb_valid) begin
                        if (ir_q[11:8] != 4'h0) begin
                            regs_q[ir_q[11:8]] <= gif.wb_data;
                        end
                        pc_q        <= pc_inc_d;
                        imem_addr_q <= pc_inc_d;
                        imem_rd_q   <= 1'b1;
                        state_q     <= S_FETCH;
                    end
                end
                default: begin
                    issue_valid_q <= 1'b0;
                    imem_rd_q     <= 1'b0;
                    busy_q        <= 1'b0;
                    halted_q      <= 1'b0;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_addr       = imem_addr_q;
    assign imem_rd         = imem_rd_q;
    assign gif.opCode      = opcode_q;
    assign gif.A_in        = a_q;
    assign gif.B_in        = b_q;
    assign gif.issue_valid = issue_valid_q;
    assign pc              = pc_q;
    assign busy            = busy_q;
    assign halted          = halted_q;

endmodule

// File: tb/tb_green_issue.sv
// Bench for green_issue: an ISA-level interpreter predicts fetch addresses and issue triples,
// a simple green stand-in answers issues, and directed programs pin the interpreter with literals.
module tb_green_issue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        start;
    logic [7:0]  start_pc;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;

    green_issue_if gif ();

    green_issue #(.PC_W(8), .RST_PC(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .start     (start),
        .start_pc  (start_pc),
        .imem_addr (imem_addr),
        .imem_rd   (imem_rd),
        .imem_data (imem_data),
        .gif       (gif),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];

    // Synchronous instruction memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem[imem_addr];
    end

    int          total = 0;
    int          bad   = 0;
    logic [15:0] mregs [16];
    logic [7:0]  exp_fetch [$];
    logic [47:0] exp_iss [$];
    logic [7:0]  m_final_pc;
    logic [7:0]  fetch_log [$];
    logic [47:0] iss_log [$];
    bit          auto_on;
    int          stall_left;
    int          stall_seen;
    bit          wb_pend;
    bit          prev_stall;
    logic [15:0] wb_res;
    logic [47:0] prev_iss;
    logic [7:0]  prev_pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic miss(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // Stand-in for green's arithmetic.
    function automatic logic [15:0] green_fn(input logic [15:0] w, input logic [15:0] a, input logic [15:0] b);
        case (w[15:12])
            4'h1:    green_fn = a + b;
            4'h2:    green_fn = 16'hFFFF;
            default: green_fn = a ^ b ^ w;
        endcase
    endfunction

    // Architectural interpreter: walks the program from spc and records what must be seen.
    function automatic void model_run(input logic [7:0] spc);
        logic [7:0]  p;
        logic [15:0] w;
        logic [15:0] a;
        logic [15:0] b;
        p = spc;
        m_final_pc = spc;
        for (int n = 0; n < 64; n++) begin
            exp_fetch.push_back(p);
            w = mem[p];
            m_final_pc = p;
            if (w[15:12] == 4'hF) break;
            if (w[15:12] == 4'hE) begin
                if (w[11:8] != 4'h0) mregs[w[11:8]] = {8'h00, w[7:0]};
                p = p + 8'd1;
            end
`ifdef GREEN_ISSUE_BRANCH_EN
            else if (w[15:12] == 4'hD) begin
                // With an 8-bit pc, adding the raw byte equals adding its sign extension.
                p = (mregs[w[11:8]] != 16'h0000) ? p + w[7:0] : p + 8'd1;
            end
`endif
            else begin
                a = mregs[w[7:4]];
                b = mregs[w[3:0]];
                exp_iss.push_back({w, a, b});
                if (w[11:8] != 4'h0) mregs[w[11:8]] = green_fn(w, a, b);
                p = p + 8'd1;
            end
        end
    endfunction

    // Per-cycle checker and green responder, run at each falling edge.
    task automatic respond();
        if (wb_pend) begin
            chk("issue_valid_after_accept", 64'(gif.issue_valid), 64'd0);
            gif.wb_valid = 1'b1;
            gif.wb_data  = wb_res;
            wb_pend      = 1'b0;
        end else begin
            gif.wb_valid = 1'b0;
        end
        if (imem_rd) begin
            fetch_log.push_back(imem_addr);
            if (exp_fetch.size() == 0) miss("fetch_unexpected");
            else chk("fetch_addr", 64'(imem_addr), 64'(exp_fetch.pop_front()));
        end
        if (prev_stall)
            chk("stall_hold", 64'({gif.opCode, gif.A_in, gif.B_in, gif.issue_valid, pc}),
                64'({prev_iss, 1'b1, prev_pc}));
        prev_stall = 1'b0;
        if (gif.issue_valid && stall_left > 0) begin
            gif.issue_ready = 1'b0;
            stall_left--;
            stall_seen++;
            prev_stall = 1'b1;
            prev_iss   = {gif.opCode, gif.A_in, gif.B_in};
            prev_pc    = pc;
        end else if (gif.issue_valid) begin
            gif.issue_ready = 1'b1;
            iss_log.push_back({gif.opCode, gif.A_in, gif.B_in});
            if (exp_iss.size() == 0) miss("issue_unexpected");
            else chk("issue", 64'({gif.opCode, gif.A_in, gif.B_in}), 64'(exp_iss.pop_front()));
            wb_res  = green_fn(gif.opCode, gif.A_in, gif.B_in);
            wb_pend = 1'b1;
        end else begin
            gif.issue_ready = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (auto_on) respond();
    endtask

    task automatic run_prog(input logic [7:0] spc);
        int c;
        model_run(spc);
        fetch_log.delete();
        iss_log.delete();
        start_pc = spc;
        start    = 1'b1;
        step();
        start = 1'b0;
        chk("fetch_after_start", 64'({imem_rd, imem_addr}), 64'({1'b1, spc}));
        c = 0;
        while (!halted && c < 500) begin
            step();
            c++;
        end
        chk("halt_reached", 64'(halted), 64'd1);
        chk("fetch_queue_drained", 64'(exp_fetch.size()), 64'd0);
        chk("issue_queue_drained", 64'(exp_iss.size()), 64'd0);
        chk("halt_pc", 64'(pc), 64'(m_final_pc));
        chk("busy_at_halt", 64'(busy), 64'd0);
        exp_fetch.delete();
        exp_iss.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        rst_n = 1'b0; en = 1'b1; start = 1'b0; start_pc = 8'h00;
        gif.issue_ready = 1'b0; gif.wb_valid = 1'b0; gif.wb_data = 16'h0000;
        auto_on = 1'b0; stall_left = 0; stall_seen = 0; wb_pend = 1'b0; prev_stall = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
        for (int i = 0; i < 16; i++) mregs[i] = 16'h0000;

        step(); step();
        chk("reset_ctrl", 64'({busy, halted, imem_rd, gif.issue_valid, pc, imem_addr}), 64'd0);
        chk("reset_issue", 64'({gif.opCode, gif.A_in, gif.B_in}), 64'd0);
        rst_n = 1'b1;
        step(); step();
        chk("idle_before_start", 64'({busy, halted, imem_rd, gif.issue_valid, pc, imem_addr}), 64'd0);

        // Arithmetic program with a 5-cycle ready stall on the first issue.
        mem[8'h10] = 16'hE112; mem[8'h11] = 16'hE234; mem[8'h12] = 16'h1312;
        mem[8'h13] = 16'h3433; mem[8'h14] = 16'h2050; mem[8'h15] = 16'h3500;
        mem[8'h16] = 16'hF000;
        auto_on = 1'b1;
        stall_left = 5;
        run_prog(8'h10);
        chk("stall_cycles", 64'(stall_seen), 64'd5);
        chk("halt_pc_literal", 64'(pc), 64'h16);
        if (iss_log.size() == 4) begin
            chk("add_issue_literal", 64'(iss_log[0]), 64'({16'h1312, 16'h0012, 16'h0034}));
            chk("r3_result_literal", 64'(iss_log[1][47:16]), 64'({16'h3433, 16'h0046}));
            chk("r0_reads_zero", 64'(iss_log[3]), 64'({16'h3500, 16'h0000, 16'h0000}));
        end else chk("prog1_issue_count", 64'(iss_log.size()), 64'd4);

        // Halt at the top of memory, then restart there and wrap.
        mem[8'hFE] = 16'hE701; mem[8'hFF] = 16'hF000;
        run_prog(8'hFE);
        chk("halt_at_ff", 64'({halted, pc}), 64'({1'b1, 8'hFF}));
        mem[8'hFF] = 16'hE702; mem[8'h00] = 16'hF000;
        run_prog(8'hFF);
        if (fetch_log.size() == 2) chk("wrap_fetch", 64'(fetch_log[1]), 64'h00);
        else chk("wrap_fetch_count", 64'(fetch_log.size()), 64'd2);

        // Op 4'hD: branch when built with the option, issued to green otherwise.
        mem[8'h20] = 16'hE101; mem[8'h21] = 16'hF000;
        run_prog(8'h20);
        mem[8'h03] = 16'hE100; mem[8'h04] = 16'h0000; mem[8'h05] = 16'hD1FE; mem[8'h06] = 16'hF000;
        run_prog(8'h05);
`ifdef GREEN_ISSUE_BRANCH_EN
        if (fetch_log.size() == 5) begin
            chk("bnz_taken", 64'(fetch_log[1]), 64'h03);
            chk("bnz_not_taken", 64'(fetch_log[4]), 64'h06);
        end else chk("bnz_fetch_count", 64'(fetch_log.size()), 64'd5);
`else
        if (iss_log.size() == 1 && fetch_log.size() == 2) begin
            chk("d_op_issued", 64'(iss_log[0][47:32]), 64'hD1FE);
            chk("d_op_next_fetch", 64'(fetch_log[1]), 64'h06);
        end else chk("d_op_log_count", 64'({iss_log.size(), fetch_log.size()}), 64'({32'd1, 32'd2}));
`endif

        // Enable gating during writeback, driven by hand.
        auto_on = 1'b0;
        gif.issue_ready = 1'b0; gif.wb_valid = 1'b0;
        mem[8'h30] = 16'h1612; mem[8'h31] = 16'h3766; mem[8'h32] = 16'hF000;
        start_pc = 8'h30; start = 1'b1;
        step();
        start = 1'b0;
        c = 0;
        while (!gif.issue_valid && c < 20) begin step(); c++; end
        chk("man_issue_seen", 64'(gif.issue_valid), 64'd1);
        gif.issue_ready = 1'b1;
        step();
        gif.issue_ready = 1'b0;
        chk("man_accept_drops_valid", 64'(gif.issue_valid), 64'd0);
        en = 1'b0; gif.wb_valid = 1'b1; gif.wb_data = 16'hABCD;
        step();
        gif.wb_valid = 1'b0; en = 1'b1;
        step(); step();
        chk("en_low_wb_held", 64'({busy, imem_rd, pc}), 64'({1'b1, 1'b0, 8'h30}));
        gif.wb_valid = 1'b1; gif.wb_data = 16'h1234;
        step();
        gif.wb_valid = 1'b0;
        chk("wb_then_fetch", 64'({imem_rd, imem_addr}), 64'({1'b1, 8'h31}));
        c = 0;
        while (!gif.issue_valid && c < 20) begin step(); c++; end
        chk("wb_value_read", 64'({gif.opCode, gif.A_in, gif.B_in}), 64'({16'h3766, 16'h1234, 16'h1234}));

        // Asynchronous reset while an issue is pending.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_drops_valid", 64'(gif.issue_valid), 64'd0);
        chk("rst_ctrl", 64'({busy, halted, imem_rd, pc, imem_addr}), 64'd0);
        chk("rst_issue", 64'({gif.opCode, gif.A_in, gif.B_in}), 64'd0);
        for (int i = 0; i < 16; i++) mregs[i] = 16'h0000;
        step();
        rst_n = 1'b1;
        step(); step();
        chk("idle_after_rst", 64'({busy, halted, imem_rd}), 64'd0);

        mem[8'h40] = 16'h3766; mem[8'h41] = 16'hF000;
        auto_on = 1'b1;
        run_prog(8'h40);
        if (iss_log.size() == 1) chk("regs_cleared", 64'(iss_log[0]), 64'({16'h3766, 16'h0000, 16'h0000}));
        else chk("regs_cleared_count", 64'(iss_log.size()), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
